// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: turns load/store into a
// req/ack bus transaction and holds Stall_M until it completes.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   MemRead_M, MemWrite_M   load / store in MEM (both set = store)
//   Flush_M                 kill MEM instruction (only in IDLE)
//   ALUOut_M, WriteData_M   effective address, store data
//   mem_req/we/addr/wdata   registered bus request
//   mem_ack, mem_rdata      bus completion pulse, read data
//   Stall_M                 combinational pipeline freeze
//   ReadData_M              load result to MEM/WB
//   bus_err                 sticky timeout flag
//   misalign_M              misaligned-op trap pulse (MISALIGN_TRAP_EN)
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned ops;
// otherwise the low two address bits are dropped.

module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_M,
    input  logic              MemWrite_M,
    input  logic              Flush_M,
    input  logic [ADDR_W-1:0] ALUOut_M,
    input  logic [DATA_W-1:0] WriteData_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Stall_M,
    output logic [DATA_W-1:0] ReadData_M,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_M,
`endif
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              op;
    logic              misaligned;
    logic              issue;
    logic              tmo_hit;
    logic              stall_d;
    logic [ADDR_W-1:0] bus_addr;

    assign op = (MemRead_M | MemWrite_M) & ~Flush_M;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = op & (ALUOut_M[1:0] != 2'b00);
    assign bus_addr   = ALUOut_M;
    assign misalign_M = rst_n & (state_q == IDLE) & misaligned;
`else
    logic unused_addr_lo;
    assign misaligned     = 1'b0;
    assign unused_addr_lo = ^ALUOut_M[1:0];
    assign bus_addr       = {ALUOut_M[ADDR_W-1:2], 2'b00};
`endif

    assign issue = op & ~misaligned;

    // Counter holds the number of REQ cycles already elapsed, so the
    // TIMEOUT-th REQ cycle is the one that sees cnt_q == TIMEOUT-1.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_d = issue;
                if (issue) state_d = REQ;
            end
            REQ: begin
                stall_d = 1'b1;
                if (mem_ack || tmo_hit) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gate with reset so the pipeline unfreezes the moment reset hits.
    assign Stall_M = stall_d & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ReadData_M <= '0;
            bus_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (issue) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_M;
                        mem_addr  <= bus_addr;
                        mem_wdata <= WriteData_M;
                    end
                    if (misaligned && !MemWrite_M) begin
                        ReadData_M <= '0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) ReadData_M <= mem_rdata;
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!mem_we) ReadData_M <= '0;
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: default-timeout instance plus
// a TIMEOUT=4 instance, selected through shared stimulus.

module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        rd, wr, flush, ack;
    logic [31:0] addr, wdata, rdata_in;

    logic        req1, we1, stall1, err1;
    logic [31:0] addr1, wd1, rdo1;
    logic        req2, we2, stall2, err2;
    logic [31:0] addr2, wd2, rdo2;
`ifdef MISALIGN_TRAP_EN
    logic        mis1, mis2;
`endif

    logic rd1, rd2, wr1, wr2, ack1, ack2;
    assign rd1  = rd & ~sel;
    assign rd2  = rd & sel;
    assign wr1  = wr & ~sel;
    assign wr2  = wr & sel;
    assign ack1 = ack & ~sel;
    assign ack2 = ack & sel;

    logic        v_req, v_we, v_stall, v_err;
    logic [31:0] v_addr, v_wdata, v_rdo;
    assign v_req   = sel ? req2 : req1;
    assign v_we    = sel ? we2 : we1;
    assign v_stall = sel ? stall2 : stall1;
    assign v_err   = sel ? err2 : err1;
    assign v_addr  = sel ? addr2 : addr1;
    assign v_wdata = sel ? wd2 : wd1;
    assign v_rdo   = sel ? rdo2 : rdo1;

    mem_access_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_M(rd1), .MemWrite_M(wr1), .Flush_M(flush),
        .ALUOut_M(addr), .WriteData_M(wdata),
        .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_ack(ack1), .mem_rdata(rdata_in),
        .Stall_M(stall1), .ReadData_M(rdo1),
`ifdef MISALIGN_TRAP_EN
        .misalign_M(mis1),
`endif
        .bus_err(err1)
    );

    mem_access_stage #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .MemRead_M(rd2), .MemWrite_M(wr2), .Flush_M(flush),
        .ALUOut_M(addr), .WriteData_M(wdata),
        .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wd2), .mem_ack(ack2), .mem_rdata(rdata_in),
        .Stall_M(stall2), .ReadData_M(rdo2),
`ifdef MISALIGN_TRAP_EN
        .misalign_M(mis2),
`endif
        .bus_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one op, ack it after ack_n REQ cycles (0 = never), and
    // return at the negedge of the first non-stalled cycle (DONE).
    task automatic run_op(
        input  logic        r, w, f_req,
        input  logic [31:0] a, wd, rdat,
        input  int          ack_n,
        output int          stalls, reqs,
        output logic [31:0] addr_seen,
        output logic        we_seen, stable, done
    );
        rd = r; wr = w; addr = a; wdata = wd;
        stalls = 0; reqs = 0; stable = 1'b1; done = 1'b0;
        addr_seen = '0; we_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (v_req) begin
                reqs++;
                if (reqs == 1) begin
                    addr_seen = v_addr;
                    we_seen   = v_we;
                end else if (v_addr !== addr_seen || v_we !== we_seen) begin
                    stable = 1'b0;
                end
                if (v_wdata !== wd) stable = 1'b0;
                if (f_req) flush = 1'b1;
            end
            ack = v_req && (reqs == ack_n);
            rdata_in = rdat;
            if (!v_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        ack = 1'b0;
    endtask

    task automatic end_op(input string tag);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; flush = 1'b0;
        @(negedge clk);
        check(tag, 32'(v_req), 32'd0);
    endtask

    int          st, rq;
    logic [31:0] as;
    logic        ws, stb, dn;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; sel = 1'b0;
        rd = 0; wr = 0; flush = 0; ack = 0;
        addr = '0; wdata = '0; rdata_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   32'(req1),   32'd0);
        check("rst_stall", 32'(stall1), 32'd0);
        check("rst_rdata", rdo1,        32'd0);
        check("rst_err",   32'(err1),   32'd0);
        check("rst_addr",  addr1,       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load, ack in first REQ cycle
        @(posedge clk); #1;
        run_op(1, 0, 0, 32'h100, 32'h0, 32'hCAFEF00D, 1,
               st, rq, as, ws, stb, dn);
        check("ld_done",   32'(dn),  32'd1);
        check("ld_stall",  32'(st),  32'd2);
        check("ld_reqs",   32'(rq),  32'd1);
        check("ld_addr",   as,       32'h100);
        check("ld_we",     32'(ws),  32'd0);
        check("ld_rdata",  v_rdo,    32'hCAFEF00D);
        end_op("ld_noreissue");

        // Store, ack after 5 REQ cycles
        @(posedge clk); #1;
        run_op(0, 1, 0, 32'h20, 32'h12345678, 32'h99999999, 5,
               st, rq, as, ws, stb, dn);
        check("st_done",   32'(dn),  32'd1);
        check("st_stall",  32'(st),  32'd6);
        check("st_reqs",   32'(rq),  32'd5);
        check("st_we",     32'(ws),  32'd1);
        check("st_addr",   as,       32'h20);
        check("st_stable", 32'(stb), 32'd1);
        check("st_rdata",  v_rdo,    32'hCAFEF00D);
        end_op("st_noreissue");

        // Read+write together is a store
        @(posedge clk); #1;
        run_op(1, 1, 0, 32'h24, 32'h0000BEEF, 32'h0000DEAD, 1,
               st, rq, as, ws, stb, dn);
        check("rw_we",     32'(ws),  32'd1);
        check("rw_rdata",  v_rdo,    32'hCAFEF00D);
        end_op("rw_noreissue");

        // Stray ack in IDLE
        @(posedge clk); #1;
        ack = 1'b1; rdata_in = 32'h11111111;
        @(negedge clk);
        check("stray_stall", 32'(v_stall), 32'd0);
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        check("stray_rdata", v_rdo, 32'hCAFEF00D);
        check("stray_req",   32'(v_req), 32'd0);

        // Flush in IDLE suppresses the request
        @(posedge clk); #1;
        rd = 1'b1; flush = 1'b1; addr = 32'h180;
        @(negedge clk);
        check("fl_idle_stall", 32'(v_stall), 32'd0);
        @(posedge clk); #1;
        rd = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("fl_idle_req", 32'(v_req), 32'd0);

        // Flush during REQ is ignored
        @(posedge clk); #1;
        run_op(1, 0, 1, 32'h200, 32'h0, 32'h0BADBEEF, 3,
               st, rq, as, ws, stb, dn);
        check("fl_req_done",  32'(dn), 32'd1);
        check("fl_req_stall", 32'(st), 32'd4);
        check("fl_req_rdata", v_rdo,   32'h0BADBEEF);
        end_op("fl_req_noreissue");

`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        rd = 1'b1; addr = 32'h102;
        @(negedge clk);
        check("mis_pulse", 32'(mis1),   32'd1);
        check("mis_stall", 32'(stall1), 32'd0);
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        check("mis_req",   32'(req1), 32'd0);
        check("mis_clear", 32'(mis1), 32'd0);
        check("mis_rdata", rdo1,      32'd0);
`else
        @(posedge clk); #1;
        run_op(1, 0, 0, 32'h102, 32'h0, 32'h55AA55AA, 1,
               st, rq, as, ws, stb, dn);
        check("mis_addr",  as,    32'h100);
        check("mis_rdata", v_rdo, 32'h55AA55AA);
        end_op("mis_noreissue");
`endif

        // Async reset mid-REQ with the op still on the inputs
        @(posedge clk); #1;
        rd = 1'b1; addr = 32'h300;
        @(posedge clk); #1;
        check("mid_req_up", 32'(req1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req",   32'(req1),   32'd0);
        check("mid_rst_stall", 32'(stall1), 32'd0);
        check("mid_rst_rdata", rdo1,        32'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // TIMEOUT=4 instance: ack on 4th REQ cycle still completes
        sel = 1'b1;
        @(posedge clk); #1;
        run_op(1, 0, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 4,
               st, rq, as, ws, stb, dn);
        check("to_ack_reqs",  32'(rq),    32'd4);
        check("to_ack_stall", 32'(st),    32'd5);
        check("to_ack_rdata", v_rdo,      32'hA5A5A5A5);
        check("to_ack_err",   32'(v_err), 32'd0);
        end_op("to_ack_noreissue");

        // No ack at all: bus error after 4 REQ cycles
        @(posedge clk); #1;
        run_op(1, 0, 0, 32'h44, 32'h0, 32'h77777777, 0,
               st, rq, as, ws, stb, dn);
        check("to_done",  32'(dn),    32'd1);
        check("to_reqs",  32'(rq),    32'd4);
        check("to_stall", 32'(st),    32'd5);
        check("to_err",   32'(v_err), 32'd1);
        check("to_rdata", v_rdo,      32'd0);
        end_op("to_noreissue");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("to_err_sticky", 32'(err2), 32'd1);
        check("dut1_no_err",   32'(err1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
